// File: rtl/bc6502_pkg.sv
// bc6502 shared types and constants.
// Interrupt sequencer states, vectors, stack page and SR bits.
package bc6502_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PSH_PCH,
    PSH_PCL,
    PSH_SR,
    VEC_L,
    VEC_H,
    INT4
  } int_state_t;

  localparam logic [15:0] VEC_NMI = 16'hFFFA;
  localparam logic [15:0] VEC_RST = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ = 16'hFFFE;

  localparam logic [7:0] STACK_PAGE = 8'h01;

  localparam int SR_I = 2;
  localparam int SR_B = 4;
  localparam int SR_U = 5;

  function automatic logic [7:0] push_sr(
    input logic [7:0] sr,
    input logic       b
  );
    logic [7:0] s;
    s       = sr;
    s[SR_U] = 1'b1;
    s[SR_B] = b;
    return s;
  endfunction

endpackage

// File: rtl/bc6502_int_seq.sv
// bc6502 interrupt entry sequencer: push PC/SR, fetch vector.
// BC6502_RST_VEC_EN: run a reset-vector fetch after reset release.
import bc6502_pkg::*;

module bc6502_int_seq #(
  parameter logic [15:0] NMI_VEC = VEC_NMI,
  parameter logic [15:0] IRQ_VEC = VEC_IRQ,
  parameter logic [15:0] RST_VEC = VEC_RST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_ce,
  input  logic        start,
  input  logic        firq,
  input  logic        fbrk,
  input  logic        fnmi,
  input  logic [15:0] pc_i,
  input  logic [7:0]  sr_i,
  input  logic [7:0]  sp_i,
  input  logic        ack_i,
  input  logic [7:0]  dat_i,
  output logic        cyc_o,
  output logic        we_o,
  output logic [15:0] adr_o,
  output logic [7:0]  dat_o,
  output logic        busy,
  output logic        s_int4,
  output logic [15:0] pc_o,
  output logic [7:0]  sp_o,
  output logic        set_i
);

  int_state_t  state, state_n;
  logic [15:0] pc_q;
  logic [7:0]  sr_q;
  logic [7:0]  sp_q;
  logic [15:0] vec_q;
  logic        any_f;
  logic        go;
  logic        adv;
  logic        boot;

`ifdef BC6502_RST_VEC_EN
  logic rst_pend;

  // Pending reset-vector fetch, armed by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rst_pend <= 1'b1;
    else if (pipe_ce && state == IDLE)
      rst_pend <= 1'b0;
  end

  assign boot = rst_pend;
  assign busy = (state != IDLE) | (rst_pend & rst_n);
`else
  logic unused_rst_vec;
  assign unused_rst_vec = ^RST_VEC;
  assign boot = 1'b0;
  assign busy = (state != IDLE);
`endif

  assign any_f = firq | fbrk | fnmi;
  assign go    = start & any_f & ~boot;
  assign adv   = pipe_ce & ack_i;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Next state and bus outputs.
  always_comb begin
    state_n = state;
    cyc_o   = 1'b0;
    we_o    = 1'b0;
    adr_o   = 16'h0000;
    dat_o   = 8'h00;
    s_int4  = 1'b0;
    set_i   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pipe_ce && boot)
          state_n = VEC_L;
        else if (pipe_ce && go)
          state_n = PSH_PCH;
      end
      PSH_PCH: begin
        cyc_o = 1'b1;
        we_o  = 1'b1;
        adr_o = {STACK_PAGE, sp_q};
        dat_o = pc_q[15:8];
        if (adv) state_n = PSH_PCL;
      end
      PSH_PCL: begin
        cyc_o = 1'b1;
        we_o  = 1'b1;
        adr_o = {STACK_PAGE, sp_q};
        dat_o = pc_q[7:0];
        if (adv) state_n = PSH_SR;
      end
      PSH_SR: begin
        cyc_o = 1'b1;
        we_o  = 1'b1;
        adr_o = {STACK_PAGE, sp_q};
        dat_o = sr_q;
        if (adv) state_n = VEC_L;
      end
      VEC_L: begin
        cyc_o = 1'b1;
        adr_o = vec_q;
        if (adv) state_n = VEC_H;
      end
      VEC_H: begin
        cyc_o = 1'b1;
        adr_o = vec_q + 16'd1;
        if (adv) state_n = INT4;
      end
      INT4: begin
        s_int4 = 1'b1;
        set_i  = 1'b1;
        if (pipe_ce) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Latched context, stack pointer, vector and fetched PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= 16'h0000;
      sr_q  <= 8'h00;
      sp_q  <= 8'hFF;
      vec_q <= 16'h0000;
      pc_o  <= 16'h0000;
    end else if (pipe_ce) begin
      unique case (state)
        IDLE: begin
          if (boot) begin
            vec_q <= RST_VEC;
            sp_q  <= 8'hFD;
          end else if (go) begin
            pc_q  <= pc_i;
            sr_q  <= push_sr(sr_i, fbrk & ~fnmi);
            sp_q  <= sp_i;
            vec_q <= fnmi ? NMI_VEC : IRQ_VEC;
          end
        end
        PSH_PCH, PSH_PCL: begin
          if (ack_i) sp_q <= sp_q - 8'd1;
        end
        PSH_SR: begin
          if (ack_i) begin
            sp_q <= sp_q - 8'd1;
            if (fnmi) vec_q <= NMI_VEC;
          end
        end
        VEC_L: begin
          if (ack_i) pc_o[7:0] <= dat_i;
        end
        VEC_H: begin
          if (ack_i) pc_o[15:8] <= dat_i;
        end
        default: ;
      endcase
    end
  end

  assign sp_o = sp_q;

endmodule

// File: doc/bc6502_int_seq.md
Name: bc6502_int_seq

Overview:
- Interrupt entry sequencer for the bc6502 core; sits directly downstream of the interrupt-type flag logic.
- Consumes the firq/fbrk/fnmi flags and runs the 6502 entry sequence:
  - pushes PCH, PCL and SR to page 1;
  - fetches the vector;
  - hands the new PC and SP back to the core.
- Emits s_int4, which the flag logic uses to clear its flags.

Parameters:
- NMI_VEC, 16'hFFFA, NMI vector address (low byte; high byte at +1)
- IRQ_VEC, 16'hFFFE, IRQ/BRK vector address
- RST_VEC, 16'hFFFC, reset vector address (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- pipe_ce  in  1  pipeline clock enable; all state advances only when high
- start  in  1  request to begin the entry sequence (core asserts at sync/exec)
- firq  in  1  IRQ flag
- fbrk  in  1  BRK flag
- fnmi  in  1  NMI flag
- pc_i  in  16  return PC to push
- sr_i  in  8  status register to push
- sp_i  in  8  current stack pointer
- ack_i  in  1  memory cycle complete
- dat_i  in  8  memory read data
- cyc_o  out  1  memory cycle active
- we_o  out  1  write strobe
- adr_o  out  16  memory address
- dat_o  out  8  write data
- busy  out  1  sequence in progress (state != IDLE)
- s_int4  out  1  one-cycle strobe in the final (INT4) state
- pc_o  out  16  fetched vector, valid with s_int4
- sp_o  out  8  updated stack pointer, valid with s_int4
- set_i  out  1  pulse with s_int4; core sets I flag

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE.
  - cyc_o, we_o, busy, s_int4 and set_i = 0.
  - adr_o, dat_o and pc_o = 0; sp_o = 8'hFF.
- Reset mid-sequence aborts immediately; no partial-cycle completion.
- States: IDLE → PSH_PCH → PSH_PCL → PSH_SR → VEC_L → VEC_H → INT4 → IDLE.
- IDLE:
  - Leaves only if pipe_ce & start & (firq | fbrk | fnmi).
  - start with no flag set is ignored.
  - On leaving, latches pc_i, sr_i and sp_i into an internal SP copy, and latches the type.
- Push states:
  - cyc_o = 1, we_o = 1, adr_o = {8'h01, sp}.
  - dat_o = PCH, PCL, then SR in the respective states.
  - On ack_i & pipe_ce: sp decrements modulo 256 (8'h00 → 8'hFF) and the state advances.
- Pushed SR:
  - bit5 forced to 1;
  - bit4 (B) = 1 only if the latched type is BRK with no NMI, else 0.
- NMI hijack:
  - fnmi is sampled on the PSH_SR → VEC_L transition.
  - If high, the vector switches to NMI_VEC even if IRQ/BRK started the sequence.
  - The pushed B bit is unchanged.
- Vector priority at start: NMI > BRK > IRQ; BRK and IRQ share IRQ_VEC.
- Vector states:
  - VEC_L: cyc_o = 1, we_o = 0, adr_o = vec; on ack_i captures dat_i into pc_o[7:0].
  - VEC_H: adr_o = vec+1; on ack_i captures dat_i into pc_o[15:8].
- INT4 lasts exactly one pipe_ce-qualified cycle:
  - s_int4 = set_i = 1, cyc_o = 0, sp_o = final sp (sp_i − 3 mod 256);
  - then returns to IDLE.
- Wait states:
  - Each memory state holds with stable outputs until ack_i.
  - ack_i in IDLE or INT4 is ignored.
- pipe_ce low: all registers hold, including mid-handshake; an ack_i seen while pipe_ce is low is not counted.
- start while busy: ignored.
- Flag changes after the latch are ignored, except the hijack check above.
- Minimum latency, start to s_int4: 6 cycles with zero-wait ack.

Optional Feature:
- Macro: BC6502_RST_VEC_EN.
- Defined:
  - After rst_n deasserts, the first pipe_ce cycle enters VEC_L directly with vec = RST_VEC.
  - No pushes are made.
  - Then proceeds VEC_H → INT4 with sp_o = 8'hFD and set_i = 1.
  - busy is high from reset release until this completes.
  - start is ignored until then.
- Undefined: reset leaves the block in IDLE; the core supplies the reset PC externally.

Decomposition:
- Shared package bc6502_pkg holds:
  - the state enum (IDLE, PSH_PCH, PSH_PCL, PSH_SR, VEC_L, VEC_H, INT4);
  - vector address constants;
  - the STACK_PAGE constant 8'h01;
  - SR bit indices (B = 4, U = 5, I = 2).
- No sub-module needed; vector select and SR formatting stay as internal combinational logic.

Test Plan:
- IRQ, zero-wait memory:
  - Stimulus: firq = 1, start, pc_i = 16'h1234, sr_i = 8'h00, sp_i = 8'hFF; mem[FFFE/FFFF] = 34/12.
  - Required: writes 01FF←12, 01FE←34, 01FD←20; reads FFFE then FFFF.
  - Required: s_int4 on cycle 6 with pc_o = 16'h1234, sp_o = 8'hFC.
- BRK:
  - Stimulus: fbrk = 1, sr_i = 8'h00.
  - Required: pushed SR = 8'h30; vector read from FFFE.
- NMI hijack:
  - Stimulus: firq start; fnmi raised during PSH_PCL.
  - Required: reads FFFA/FFFB; pushed SR bit4 = 0.
- Wait states and stall:
  - Stimulus: ack_i delayed 3 cycles on each access; pipe_ce toggled 0 for 2 cycles mid-VEC_L.
  - Required: adr_o/cyc_o stable throughout; same final pc_o; s_int4 exactly once.
- Stack wrap:
  - Stimulus: sp_i = 8'h01.
  - Required: pushes at 0101, 0100, 01FF; sp_o = 8'hFE.
- Async reset during PSH_SR:
  - Stimulus: rst_n low for 1 cycle.
  - Required: cyc_o drops in the same cycle, state = IDLE, no s_int4.
  - With BC6502_RST_VEC_EN, additionally: read FFFC/FFFD, then s_int4 with sp_o = 8'hFD.
